// File: rtl/missile_pkg.sv
// rtl/missile_pkg.sv - shared geometry, colours, FSM states and LFSR helper for the missile path generator
package missile_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

    // Feedback taps for x^8+x^6+x^5+x^4+1, shift-left Fibonacci form
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_EMIT,
        S_WAIT
`ifdef ERASE_EN
        ,
        S_ERASE
`endif
    } state_t;

endpackage

// File: rtl/line_stepper.sv
// rtl/line_stepper.sv - Bresenham core walking from (x0,0) to (x1,SCREEN_H-1), one pixel per step
module line_stepper
    import missile_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           init_i,
    input  logic           step_i,
    input  logic [X_W-1:0] x0_i,
    input  logic [X_W-1:0] x1_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           done_o
);

    localparam int EW = X_W + 2;
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic signed [EW:0] DY = $signed((EW + 1)'(SCREEN_H - 1));

    logic [X_W-1:0]       x_q, x_d, x1_q, x1_d, dx_q, dx_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic signed [EW-1:0] err_q, err_d;
    logic                 dir_q, dir_d;
    logic signed [EW:0]   e2, dx_s, err_w;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        x1_d  = x1_q;
        dx_d  = dx_q;
        err_d = err_q;
        dir_d = dir_q;
        dx_s  = $signed({3'b000, dx_q});
        e2    = $signed({err_q, 1'b0});
        err_w = {err_q[EW-1], err_q};
        if (init_i) begin
            x_d   = x0_i;
            y_d   = '0;
            x1_d  = x1_i;
            dir_d = (x1_i >= x0_i);
            dx_d  = dir_d ? (x1_i - x0_i) : (x0_i - x1_i);
            err_w = $signed({3'b000, dx_d}) - DY;
            err_d = err_w[EW-1:0];
        end else if (step_i) begin
            // Both tests use the pre-step e2 so a diagonal move can happen in one step
            if (e2 > -DY) begin
                err_w = err_w - DY;
                x_d   = dir_q ? (x_q + X_W'(1)) : (x_q - X_W'(1));
            end
            if (e2 < dx_s) begin
                err_w = err_w + dx_s;
                y_d   = y_q + Y_W'(1);
            end
            err_d = err_w[EW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            x1_q  <= '0;
            dx_q  <= '0;
            err_q <= '0;
            dir_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            x1_q  <= x1_d;
            dx_q  <= dx_d;
            err_q <= err_d;
            dir_q <= dir_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = (y_q == Y_LAST) && (x_q == x1_q);

endmodule

// File: rtl/missile_path_gen.sv
// rtl/missile_path_gen.sv - enemy missile pixel stream: spawn, paced Bresenham walk, impact/kill
// Define ERASE_EN to replay the accepted trail in black after a kill.
module missile_path_gen
    import missile_pkg::*;
#(
    parameter int         STEP_DIV = 4,
    parameter logic [2:0] MCOLOUR  = RED
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           launch,
    input  logic [X_W-1:0] target_x,
    input  logic           kill,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [2:0]     out_colour,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           active,
    output logic           impact,
    output logic [X_W-1:0] impact_x
);

    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
    localparam int CW = X_W + 1;

    state_t         state_q, state_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic [X_W-1:0] tgt_q, tgt_d, sx_q, sx_d, impact_x_q, impact_x_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [CW-1:0]  pix_cnt_q, pix_cnt_d;
`ifdef ERASE_EN
    logic [CW-1:0]  erase_cnt_q, erase_cnt_d;
`endif
    logic           kill_pend_q, kill_pend_d, impact_q, impact_d;
    logic           st_init, st_step, st_done, end_flight, valid;
    logic [X_W-1:0] st_x;
    logic [Y_W-1:0] st_y;
    logic [2:0]     colour;

    line_stepper u_stepper (
        .clk    (clk),
        .rst    (rst),
        .init_i (st_init),
        .step_i (st_step),
        .x0_i   (sx_q),
        .x1_i   (tgt_q),
        .x_o    (st_x),
        .y_o    (st_y),
        .done_o (st_done)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        tgt_d       = tgt_q;
        sx_d        = sx_q;
        impact_x_d  = impact_x_q;
        tick_d      = tick_q;
        pix_cnt_d   = pix_cnt_q;
`ifdef ERASE_EN
        erase_cnt_d = erase_cnt_q;
`endif
        kill_pend_d = kill_pend_q;
        impact_d    = 1'b0;
        st_init     = 1'b0;
        st_step     = 1'b0;
        end_flight  = 1'b0;
        valid       = 1'b0;
        colour      = BLACK;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    tgt_d       = (target_x > X_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : target_x;
                    sx_d        = (lfsr_q >= 8'(SCREEN_W)) ? X_W'(lfsr_q - 8'(SCREEN_W)) : X_W'(lfsr_q);
                    lfsr_d      = lfsr_next(lfsr_q);
                    impact_x_d  = '0;
                    pix_cnt_d   = '0;
                    kill_pend_d = 1'b0;
                    state_d     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                st_init = 1'b1;
                tick_d  = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                valid  = 1'b1;
                colour = MCOLOUR;
                if (out_ready) begin
                    // Reaching the ground beats any kill seen during this pixel
                    if (st_done) begin
                        impact_d   = 1'b1;
                        impact_x_d = st_x;
                        state_d    = S_IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CW'(1);
                        if (kill || kill_pend_q) begin
                            end_flight = 1'b1;
                        end else begin
                            st_step = 1'b1;
                            tick_d  = '0;
                            state_d = S_WAIT;
                        end
                    end
                end else if (kill) begin
                    kill_pend_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (kill) begin
                    end_flight = 1'b1;
                end else if (frame_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = S_EMIT;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef ERASE_EN
            S_ERASE: begin
                valid  = 1'b1;
                colour = BLACK;
                if (out_ready) begin
                    if ((erase_cnt_q + CW'(1)) == pix_cnt_q) begin
                        state_d = S_IDLE;
                    end else begin
                        erase_cnt_d = erase_cnt_q + CW'(1);
                        st_step     = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (end_flight) begin
            kill_pend_d = 1'b0;
`ifdef ERASE_EN
            state_d     = S_ERASE;
            st_init     = 1'b1;
            erase_cnt_d = '0;
`else
            state_d     = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            tgt_q       <= '0;
            sx_q        <= '0;
            impact_x_q  <= '0;
            tick_q      <= '0;
            pix_cnt_q   <= '0;
`ifdef ERASE_EN
            erase_cnt_q <= '0;
`endif
            kill_pend_q <= 1'b0;
            impact_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tgt_q       <= tgt_d;
            sx_q        <= sx_d;
            impact_x_q  <= impact_x_d;
            tick_q      <= tick_d;
            pix_cnt_q   <= pix_cnt_d;
`ifdef ERASE_EN
            erase_cnt_q <= erase_cnt_d;
`endif
            kill_pend_q <= kill_pend_d;
            impact_q    <= impact_d;
        end
    end

    assign out_valid  = valid;
    assign out_x      = valid ? st_x : '0;
    assign out_y      = valid ? st_y : '0;
    assign out_colour = colour;
    assign active     = (state_q != S_IDLE);
    assign impact     = impact_q;
    assign impact_x   = impact_x_q;

endmodule

// File: tb/tb_missile_path_gen.sv
// tb/tb_missile_path_gen.sv - randomized directed bench for missile_path_gen against an integer path model
module tb_missile_path_gen;

    localparam int STEP_DIV = 2;
    localparam int SW       = 160;
    localparam int SH       = 120;
    localparam logic [2:0] MC = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       launch = 1'b0;
    logic       kill = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] target_x = 8'd0;
    logic [7:0] out_x, impact_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_valid, active, impact;

    int errors = 0;
    int checks = 0;
    int m_lfsr = 'hA5;
    int px[$];
    int py[$];

    missile_path_gen #(.STEP_DIV(STEP_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .launch     (launch),
        .target_x   (target_x),
        .kill       (kill),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .active     (active),
        .impact     (impact),
        .impact_x   (impact_x)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lfsr_adv(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    task automatic build_path(input int sx, input int tgt);
        int x, y, dx, dy, sd, err, e2;
        px.delete();
        py.delete();
        x = sx; y = 0; dy = SH - 1;
        dx = (tgt >= sx) ? tgt - sx : sx - tgt;
        sd = (tgt >= sx) ? 1 : -1;
        err = dx - dy;
        px.push_back(x); py.push_back(y);
        while (!(x == tgt && y == dy)) begin
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sd; end
            if (e2 < dx)  begin err += dx; y += 1; end
            px.push_back(x); py.push_back(y);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, out_x, 0);
        chk({tag, "_y"}, out_y, 0);
        chk({tag, "_colour"}, out_colour, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_impact"}, impact, 0);
        chk({tag, "_impact_x"}, impact_x, 0);
    endtask

    task automatic emit_pixel(input int k, input logic [2:0] col, input bit stall5,
                              input bit kill_first, input bit kill_on_accept, output bit ok);
        int stall;
        bit kf;
        stall = stall5 ? 5 : 0;
        kf = kill_first;
        ok = 1'b0;
        for (int b = 0; b < 60; b++) begin
            chk("emit_valid", out_valid, 1);
            chk("emit_x", out_x, px[k]);
            chk("emit_y", out_y, py[k]);
            chk("emit_colour", out_colour, col);
            chk("emit_active", active, 1);
            launch = ($urandom_range(0, 7) == 0);
            target_x = 8'($urandom);
            frame_tick = 1'($urandom_range(0, 1));
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if (kf) begin
                out_ready = 1'b0;
                kill = 1'b1;
                kf = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready && kill_on_accept) kill = 1'b1;
            step();
            kill = 1'b0;
            launch = 1'b0;
            frame_tick = 1'b0;
            if (out_ready) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        if (!ok) chk("emit_timeout", 0, 1);
    endtask

    task automatic wait_ticks(input bit do_kill, output bit ok);
        int ticks;
        ticks = 0;
        ok = 1'b0;
        for (int b = 0; b < 200; b++) begin
            if (ticks >= STEP_DIV) begin
                ok = 1'b1;
                break;
            end
            chk("wait_valid", out_valid, 0);
            chk("wait_active", active, 1);
            frame_tick = 1'($urandom_range(0, 1));
            launch = ($urandom_range(0, 7) == 0);
            target_x = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            kill = do_kill;
            step();
            kill = 1'b0;
            launch = 1'b0;
            if (do_kill) begin
                ok = 1'b1;
                break;
            end
            if (frame_tick) ticks++;
        end
        frame_tick = 1'b0;
        out_ready = 1'b0;
        if (!ok) chk("wait_timeout", 0, 1);
    endtask

    task automatic end_after_kill(input int n);
`ifdef ERASE_EN
        bit ok;
        for (int j = 0; j < n; j++) begin
            emit_pixel(j, 3'b000, 1'b0, 1'b0, 1'b0, ok);
            if (!ok) break;
        end
`else
        chk("kill_count", (n > 0), 1);
`endif
        chk("kill_active", active, 0);
        chk("kill_valid", out_valid, 0);
        chk("kill_impact", impact, 0);
    endtask

    task automatic start_flight(input int tx, output int tgt);
        int sx;
        sx = (m_lfsr >= SW) ? m_lfsr - SW : m_lfsr;
        tgt = (tx > SW - 1) ? SW - 1 : tx;
        m_lfsr = lfsr_adv(m_lfsr);
        build_path(sx, tgt);
        launch = 1'b1;
        target_x = 8'(tx);
        step();
        launch = 1'b0;
        chk("spawn_active", active, 1);
        chk("spawn_valid", out_valid, 0);
        kill = 1'b1;
        step();
        kill = 1'b0;
    endtask

    // mode: 0 none, 1 kill in WAIT after kill_n pixels, 2 kill flagged in EMIT on pixel kill_n-1, 3 kill on final accept
    task automatic fly(input int tx, input int mode, input int kill_n, input int stall_k);
        int tgt, n;
        bit ok;
        start_flight(tx, tgt);
        n = px.size();
        for (int k = 0; k < n; k++) begin
            emit_pixel(k, MC, k == stall_k, mode == 2 && k == kill_n - 1, mode == 3 && k == n - 1, ok);
            if (!ok) return;
            if (k == n - 1) begin
                chk("impact_pulse", impact, 1);
                chk("impact_x", impact_x, tgt);
                chk("impact_active", active, 0);
                chk("impact_valid", out_valid, 0);
                step();
                chk("impact_clear", impact, 0);
                chk("impact_x_hold", impact_x, tgt);
            end else if (mode == 2 && k == kill_n - 1) begin
                end_after_kill(k + 1);
                return;
            end else begin
                wait_ticks(mode == 1 && k == kill_n - 1, ok);
                if (!ok) return;
                if (mode == 1 && k == kill_n - 1) begin
                    end_after_kill(k + 1);
                    return;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            kill = 1'($urandom_range(0, 1));
            frame_tick = 1'($urandom_range(0, 1));
            step();
            kill = 1'b0;
            frame_tick = 1'b0;
            chk("idle_active", active, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_impact", impact, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        m_lfsr = 'hA5;
    endtask

    initial begin
        int tgt;
        bit ok;
        #2 rst = 1'b0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b1;
        step();
        chk_zero("post_reset");

        fly(5, 0, 0, 60);
        idle_cycles(4);
        chk("idle_impact_x", impact_x, 5);

        do_reset();
        fly(124, 0, 0, -1);
        fly(200, 0, 0, 30);
        fly($urandom_range(0, 255), 1, 10, -1);
        fly($urandom_range(0, 255), 3, 0, -1);
        fly($urandom_range(0, 255), 2, 7, -1);
        idle_cycles(3);
        fly($urandom_range(0, 255), 1, 1, -1);
        fly($urandom_range(0, 255), 0, 0, 5);

        start_flight(90, tgt);
        emit_pixel(0, MC, 1'b0, 1'b0, 1'b0, ok);
        wait_ticks(1'b0, ok);
        emit_pixel(1, MC, 1'b0, 1'b0, 1'b0, ok);
        wait_ticks(1'b0, ok);
        chk("pre_reset_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        m_lfsr = 'hA5;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_zero("after_mid_reset");
        fly(5, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
